// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared defaults and constants for the instruction-fetch stage.
//   Contents:
//     DEFAULT_ADDR_W / DEFAULT_DATA_W : default address / instruction widths
//     DEFAULT_RESET_PC                : PC loaded on reset
//     INSTR_NOP                       : canonical MIPS no-op encoding
//     PC_STEP                         : byte distance between sequential fetches
//     ptr_w()                         : pointer width for a queue of a given depth
package fetch_pkg;

    localparam int          DEFAULT_ADDR_W   = 32;
    localparam int          DEFAULT_DATA_W   = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam int          PC_STEP          = 4;

    // A depth of 1 would give $clog2 == 0; keep at least one pointer bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Synchronous DEPTH-entry FIFO of {pc, instr} pairs. DEPTH need not be a
//   power of two; pointers wrap explicitly at DEPTH-1.
//   Ports:
//     clk, reset          : rising-edge clock, synchronous active-high reset
//     flush               : drop all entries (pointers and count to zero)
//     push, push_pc/instr : write one entry at the tail
//     pop                 : retire the head entry (ignored when empty)
//     head_pc, head_instr : head entry contents (stale when empty)
//     count               : number of valid entries
//     valid               : queue holds at least one entry
//   Storage is not reset; only pointers and count are.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_pc,
    input  logic [DATA_W-1:0]          push_instr,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          head_pc,
    output logic [DATA_W-1:0]          head_instr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       valid
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              pop_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid      = (count != '0);
    assign pop_eff    = pop && valid;
    assign head_pc    = pc_mem[head];
    assign head_instr = instr_mem[head];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop_eff) begin
                head <= ptr_inc(head);
            end
            case ({push, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // The issue rule upstream must never let a push land on a full queue.
            if (push && !pop_eff) begin
                assert (count != CNT_W'(DEPTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= push_pc;
            instr_mem[tail] <= push_instr;
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   MIPS instruction-fetch stage: owns the PC, issues one request per cycle
//   to a 1-cycle-latency instruction memory, buffers responses with their PC
//   in a DEPTH-entry queue and hands them to decode.
//   Ports:
//     clk, reset            : rising-edge clock, synchronous active-high reset
//     redirect, redirect_pc : flush everything, restart at redirect_pc & ~3
//     imem_req, imem_addr   : fetch request and its word-aligned address
//     imem_rdata            : instruction for the previous cycle's request
//     out_valid, out_ready  : decode handshake
//     out_instr, out_pc     : head instruction and its PC
//     out_pc4               : out_pc + 4 (wrapping)
//     count                 : valid queue entries
//   Optional build macro: FETCH_BYPASS_EN -- when the queue is empty a
//   returning response is presented to decode in the same cycle.
//
//   Handshake: an entry transfers on a rising edge where out_valid and
//   out_ready are both high; out_valid never depends on out_ready, and the
//   head stays stable while out_valid is high and out_ready is low.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_pc4,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic              inflight;
    logic              pop;
    logic              push;
    logic              fifo_valid;
    logic              bypass_active;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;
    logic [CNT_W:0]    occupancy;

`ifdef FETCH_BYPASS_EN
    // Empty queue and a live response: show it to decode directly.
    assign bypass_active = inflight && (count == '0) && !redirect;
`else
    assign bypass_active = 1'b0;
`endif

    assign out_valid = !reset && (fifo_valid || bypass_active);
    assign out_instr = bypass_active ? imem_rdata : head_instr;
    assign out_pc    = bypass_active ? resp_pc    : head_pc;
    assign out_pc4   = out_pc + ADDR_W'(PC_STEP);
    assign pop       = out_valid && out_ready;

    // Slots already claimed (queued + in flight) minus the one freed by a
    // same-cycle pop; issuing only below DEPTH guarantees no overflow.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    assign imem_req  = !reset && !redirect && (occupancy < (CNT_W + 1)'(DEPTH));
    assign imem_addr = fetch_pc;

    // A bypassed response that decode takes never enters the queue.
    assign push = inflight && !reset && !redirect && !(bypass_active && out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~ADDR_W'(3);
            inflight <= 1'b0;
        end else if (imem_req) begin
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            resp_pc  <= fetch_pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_pc    (resp_pc),
        .push_instr (imem_rdata),
        .pop        (pop && !bypass_active),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count),
        .valid      (fifo_valid)
    );

endmodule
